// File: rtl/bcd_field_editor_if.sv
// Bundle between the debounced button front-end / RTC write-back logic and
// bcd_field_editor.
//   master: button pulses (btn_p/r/l), button levels (btn_u/d) and live_val
//           out; edit_val, cursor, state, commit, cancel in.
//   slave : the editor itself; directions mirrored.
interface bcd_field_editor_if #(
    parameter int unsigned NFIELDS = 6,
    parameter int unsigned CW      = (NFIELDS > 1) ? $clog2(NFIELDS) : 1
);
    logic                 btn_p;
    logic                 btn_r;
    logic                 btn_l;
    logic                 btn_u;
    logic                 btn_d;
    logic [8*NFIELDS-1:0] live_val;
    logic [8*NFIELDS-1:0] edit_val;
    logic [CW-1:0]        cursor;
    logic [1:0]           state;
    logic                 commit;
    logic                 cancel;

    modport master (
        output btn_p, btn_r, btn_l, btn_u, btn_d, live_val,
        input  edit_val, cursor, state, commit, cancel
    );

    modport slave (
        input  btn_p, btn_r, btn_l, btn_u, btn_d, live_val,
        output edit_val, cursor, state, commit, cancel
    );
endinterface

// File: rtl/bcd_field_editor.sv
// BCD field editor for the RTC user-control path. Loads a set of 2-digit BCD
// fields from the live values, lets the user move a cursor and step the
// selected field up/down (with auto-repeat on held buttons, wrapping inside
// per-field [FMIN, FMAX]), and finishes with a commit pulse or a timeout
// cancel pulse.
//   clk, rst_n : clock and synchronous active-low reset
//   bus (slave): btn_p/r/l pulses, btn_u/d levels, live_val in;
//                edit_val, cursor, state (IDLE/LOAD/EDIT/COMMIT),
//                commit and cancel pulses out. All outputs registered.
module bcd_field_editor #(
    parameter int unsigned          NFIELDS    = 6,
    parameter logic [8*NFIELDS-1:0] FMIN       = {8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01},
    parameter logic [8*NFIELDS-1:0] FMAX       = {8'h59, 8'h59, 8'h23, 8'h99, 8'h12, 8'h31},
    parameter int unsigned          REPEAT_DLY = 4,
    parameter int unsigned          REPEAT_PER = 2,
    parameter int unsigned          TIMEOUT    = 50
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_field_editor_if.slave  bus
);
    localparam int unsigned CW = (NFIELDS > 1) ? $clog2(NFIELDS) : 1;
    localparam int unsigned HW = $clog2(REPEAT_DLY + 2);
    localparam int unsigned RW = $clog2(REPEAT_PER + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [HW-1:0] HMAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EDIT   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [8*NFIELDS-1:0] edit_q, edit_d;
    logic [CW-1:0]        cursor_q, cursor_d;
    logic                 commit_q, commit_d;
    logic                 cancel_q, cancel_d;
    logic [TW-1:0]        to_q, to_d;
    logic [HW-1:0]        h_q, h_d;
    logic [RW-1:0]        rep_q, rep_d;
    logic                 lock_q, lock_d;
    logic                 up_prev_q, up_prev_d;
    logic                 dn_prev_q, dn_prev_d;

    logic          up_only, dn_only, new_press, held, fire, any_btn;
    logic [HW-1:0] h_cur;

    function automatic logic field_ok(input logic [7:0] v, input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi);
        if (v == hi)             return lo;
        else if (v[3:0] == 4'd9) return v + 8'h07;
        else                     return v + 8'h01;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi);
        if (v == lo)             return hi;
        else if (v[3:0] == 4'd0) return v - 8'h07;
        else                     return v - 8'h01;
    endfunction

    always_comb begin
        state_d  = state_q;
        edit_d   = edit_q;
        cursor_d = cursor_q;
        commit_d = 1'b0;
        cancel_d = 1'b0;
        to_d     = '0;
        h_d      = '0;
        rep_d    = '0;
        fire     = 1'b0;

        // Only a single pressed direction counts; both pressed holds h at 0 and
        // makes the survivor look like a fresh press when the other is released.
        up_only   = bus.btn_u & ~bus.btn_d;
        dn_only   = bus.btn_d & ~bus.btn_u;
        up_prev_d = up_only;
        dn_prev_d = dn_only;
        new_press = (up_only & ~up_prev_q) | (dn_only & ~dn_prev_q);
        held      = (up_only & up_prev_q) | (dn_only & dn_prev_q);
        any_btn   = bus.btn_p | bus.btn_r | bus.btn_l | bus.btn_u | bus.btn_d;
        h_cur     = (h_q == HMAX) ? h_q : h_q + 1'b1;

        // h saturates past REPEAT_DLY, so rep_q carries the repeat phase
        // (cycles since the previous repeat step).
        if (new_press) begin
            fire = 1'b1;
        end else if (held) begin
            h_d = h_cur;
            if (h_cur == HW'(REPEAT_DLY)) begin
                fire  = 1'b1;
                rep_d = RW'(1);
            end else if (h_cur > HW'(REPEAT_DLY)) begin
                if (rep_q == RW'(REPEAT_PER)) begin
                    fire  = 1'b1;
                    rep_d = RW'(1);
                end else begin
                    rep_d = rep_q + 1'b1;
                end
            end
        end

        // A button held across a cursor move (or into EDIT) stays inert until
        // every up/down button has been released.
        lock_d = lock_q & (bus.btn_u | bus.btn_d);

        case (state_q)
            IDLE: begin
                if (bus.btn_p) state_d = LOAD;
            end
            LOAD: begin
                for (int unsigned i = 0; i < NFIELDS; i++) begin
                    edit_d[8*i +: 8] = field_ok(bus.live_val[8*i +: 8], FMIN[8*i +: 8],
                                                FMAX[8*i +: 8])
                                       ? bus.live_val[8*i +: 8] : FMIN[8*i +: 8];
                end
                cursor_d = '0;
                lock_d   = bus.btn_u | bus.btn_d;
                state_d  = EDIT;
            end
            EDIT: begin
                if (bus.btn_p) begin
                    state_d  = COMMIT;
                    commit_d = 1'b1;
                end else if (bus.btn_r) begin
                    cursor_d = (cursor_q == CW'(NFIELDS - 1)) ? '0 : cursor_q + 1'b1;
                    h_d      = '0;
                    rep_d    = '0;
                    lock_d   = bus.btn_u | bus.btn_d;
                end else if (bus.btn_l) begin
                    cursor_d = (cursor_q == '0) ? CW'(NFIELDS - 1) : cursor_q - 1'b1;
                    h_d      = '0;
                    rep_d    = '0;
                    lock_d   = bus.btn_u | bus.btn_d;
                end else if (fire && !lock_q) begin
                    if (up_only)
                        edit_d[8*cursor_q +: 8] = bcd_inc(edit_q[8*cursor_q +: 8],
                                                          FMIN[8*cursor_q +: 8],
                                                          FMAX[8*cursor_q +: 8]);
                    else
                        edit_d[8*cursor_q +: 8] = bcd_dec(edit_q[8*cursor_q +: 8],
                                                          FMIN[8*cursor_q +: 8],
                                                          FMAX[8*cursor_q +: 8]);
                end
                if (!any_btn) begin
                    if (to_q == TW'(TIMEOUT - 1)) begin
                        state_d  = IDLE;
                        cancel_d = 1'b1;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            edit_q    <= FMIN;
            cursor_q  <= '0;
            commit_q  <= 1'b0;
            cancel_q  <= 1'b0;
            to_q      <= '0;
            h_q       <= '0;
            rep_q     <= '0;
            lock_q    <= 1'b0;
            up_prev_q <= 1'b0;
            dn_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            edit_q    <= edit_d;
            cursor_q  <= cursor_d;
            commit_q  <= commit_d;
            cancel_q  <= cancel_d;
            to_q      <= to_d;
            h_q       <= h_d;
            rep_q     <= rep_d;
            lock_q    <= lock_d;
            up_prev_q <= up_prev_d;
            dn_prev_q <= dn_prev_d;
        end
    end

    assign bus.edit_val = edit_q;
    assign bus.cursor   = cursor_q;
    assign bus.state    = state_q;
    assign bus.commit   = commit_q;
    assign bus.cancel   = cancel_q;
endmodule

// File: tb/tb_bcd_field_editor.sv
// Testbench for bcd_field_editor: directed scenarios followed by randomized
// button/live-value traffic, every cycle checked against a decimal-arithmetic
// reference model of the editor.
module tb_bcd_field_editor;
    localparam int unsigned NF  = 6;
    localparam int unsigned DLY = 4;
    localparam int unsigned PER = 2;
    localparam int unsigned TMO = 50;
    localparam logic [47:0] FMIN_P = {8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
    localparam logic [47:0] FMAX_P = {8'h59, 8'h59, 8'h23, 8'h99, 8'h12, 8'h31};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_field_editor_if #(.NFIELDS(NF)) bus ();

    bcd_field_editor #(
        .NFIELDS(NF), .FMIN(FMIN_P), .FMAX(FMAX_P),
        .REPEAT_DLY(DLY), .REPEAT_PER(PER), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state (field values kept as plain decimal numbers)
    int m_val[NF];
    int m_cur, m_st, m_dir_prev, m_n, m_idle;
    bit m_commit, m_cancel, m_blocked;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int bcd2i(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] i2bcd(input int x);
        logic [7:0] b;
        b[7:4] = 4'(x / 10);
        b[3:0] = 4'(x % 10);
        return b;
    endfunction

    function automatic int lo_of(input int i);
        return bcd2i(FMIN_P[8*i +: 8]);
    endfunction

    function automatic int hi_of(input int i);
        return bcd2i(FMAX_P[8*i +: 8]);
    endfunction

    function automatic logic [47:0] m_pack();
        logic [47:0] v;
        v = '0;
        for (int i = 0; i < NF; i++) v[8*i +: 8] = i2bcd(m_val[i]);
        return v;
    endfunction

    task automatic model_clock();
        int dir;
        bit step_ok, any, p, r, l, u, d, nb;
        logic [7:0] b;
        p = bus.btn_p; r = bus.btn_r; l = bus.btn_l; u = bus.btn_u; d = bus.btn_d;
        m_commit = 0;
        m_cancel = 0;
        if (!rst_n) begin
            for (int i = 0; i < NF; i++) m_val[i] = lo_of(i);
            m_cur = 0; m_st = 0; m_dir_prev = 0; m_n = 0; m_idle = 0; m_blocked = 0;
            return;
        end
        dir = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
        if (dir == 0)               m_n = 0;
        else if (dir == m_dir_prev) m_n++;
        else                        m_n = 0;
        m_dir_prev = dir;
        step_ok = (dir != 0) && !m_blocked &&
                  (m_n == 0 || m_n == DLY || (m_n > DLY && (m_n - DLY) % PER == 0));
        nb  = m_blocked && (u || d);
        any = p || r || l || u || d;
        case (m_st)
            0: if (p) m_st = 1;
            1: begin
                for (int i = 0; i < NF; i++) begin
                    b = bus.live_val[8*i +: 8];
                    if (b[7:4] > 9 || b[3:0] > 9 || bcd2i(b) < lo_of(i) || bcd2i(b) > hi_of(i))
                        m_val[i] = lo_of(i);
                    else
                        m_val[i] = bcd2i(b);
                end
                m_cur = 0; m_st = 2; m_idle = 0; nb = u || d;
            end
            2: begin
                if (p) begin
                    m_st = 3; m_commit = 1;
                end else if (r) begin
                    m_cur = (m_cur + 1) % NF; m_n = 0; nb = u || d;
                end else if (l) begin
                    m_cur = (m_cur + NF - 1) % NF; m_n = 0; nb = u || d;
                end else if (step_ok) begin
                    if (dir > 0)
                        m_val[m_cur] = (m_val[m_cur] == hi_of(m_cur)) ? lo_of(m_cur) : m_val[m_cur] + 1;
                    else
                        m_val[m_cur] = (m_val[m_cur] == lo_of(m_cur)) ? hi_of(m_cur) : m_val[m_cur] - 1;
                end
                if (any) m_idle = 0;
                else begin
                    m_idle++;
                    if (m_idle == TMO) begin
                        m_cancel = 1; m_st = 0; m_idle = 0;
                    end
                end
            end
            default: m_st = 0;
        endcase
        m_blocked = nb;
    endtask

    task automatic cyc(input bit p, input bit r, input bit l, input bit u, input bit d);
        bus.btn_p = p; bus.btn_r = r; bus.btn_l = l; bus.btn_u = u; bus.btn_d = d;
        @(posedge clk);
        model_clock();
        #1;
        chk("edit_val", bus.edit_val, m_pack());
        chk("cursor",   bus.cursor,   m_cur);
        chk("state",    bus.state,    m_st);
        chk("commit",   bus.commit,   m_commit);
        chk("cancel",   bus.cancel,   m_cancel);
    endtask

    task automatic idle_cyc(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        bit ru, rd, rp, rr, rl;
        logic [47:0] lv;
        int lo, hi;
        bus.btn_p = 0; bus.btn_r = 0; bus.btn_l = 0; bus.btn_u = 0; bus.btn_d = 0;
        bus.live_val = {8'h30, 8'h15, 8'h10, 8'h25, 8'h06, 8'h31};
        rst_n = 0;
        idle_cyc(2);
        chk("rst_state",  bus.state, 2'd0);
        chk("rst_edit",   bus.edit_val, 48'h000000000101);
        chk("rst_cursor", bus.cursor, 0);
        chk("rst_commit", bus.commit, 0);
        chk("rst_cancel", bus.cancel, 0);
        rst_n = 1;

        // Load with day 0x31, wrap up and down
        cyc(1, 0, 0, 0, 0);
        chk("load_state", bus.state, 2'd1);
        idle_cyc(1);
        chk("edit_state", bus.state, 2'd2);
        chk("day_load", bus.edit_val[7:0], 8'h31);
        cyc(0, 0, 0, 1, 0);
        chk("day_up_wrap", bus.edit_val[7:0], 8'h01);
        idle_cyc(1);
        cyc(0, 0, 0, 0, 1);
        chk("day_dn_wrap", bus.edit_val[7:0], 8'h31);
        idle_cyc(1);
        cyc(1, 0, 0, 0, 0);
        chk("commit_pulse", bus.commit, 1);
        idle_cyc(1);

        // Day 0x09 <-> 0x10 digit carry/borrow
        bus.live_val = {8'h30, 8'h15, 8'h10, 8'h25, 8'h06, 8'h09};
        cyc(1, 0, 0, 0, 0);
        idle_cyc(1);
        cyc(0, 0, 0, 1, 0);
        chk("day_09_up", bus.edit_val[7:0], 8'h10);
        idle_cyc(1);
        cyc(0, 0, 0, 0, 1);
        chk("day_10_dn", bus.edit_val[7:0], 8'h09);
        idle_cyc(1);

        // Cursor wrap and p-over-r priority
        cyc(0, 0, 1, 0, 0);
        chk("cur_l_wrap", bus.cursor, 5);
        cyc(0, 1, 0, 0, 0);
        chk("cur_r_wrap", bus.cursor, 0);
        cyc(1, 1, 0, 0, 0);
        chk("p_over_r_state", bus.state, 2'd3);
        chk("p_over_r_cursor", bus.cursor, 0);
        idle_cyc(1);

        // Auto-repeat on the year field starting at 0x00
        bus.live_val = {8'h30, 8'h15, 8'h10, 8'h00, 8'h06, 8'h09};
        cyc(1, 0, 0, 0, 0);
        idle_cyc(1);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 0);
        idle_cyc(1);
        chk("repeat_10", bus.edit_val[23:16], 8'h04);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 1);
        idle_cyc(1);
        chk("both_held", bus.edit_val[23:16], 8'h04);
        cyc(1, 0, 0, 0, 0);
        idle_cyc(1);

        // Clamping of invalid live values
        bus.live_val = {8'h30, 8'h3A, 8'h24, 8'h25, 8'h06, 8'h31};
        cyc(1, 0, 0, 0, 0);
        idle_cyc(1);
        chk("clamp_hour", bus.edit_val[31:24], 8'h00);
        chk("clamp_min",  bus.edit_val[39:32], 8'h00);
        chk("keep_sec",   bus.edit_val[47:40], 8'h30);

        // Timeout exactly at the 50th inactive EDIT cycle
        idle_cyc(TMO - 1);
        chk("pre_timeout_state", bus.state, 2'd2);
        idle_cyc(1);
        chk("timeout_cancel", bus.cancel, 1);
        chk("timeout_state",  bus.state, 2'd0);
        chk("timeout_commit", bus.commit, 0);
        idle_cyc(1);
        chk("cancel_one_shot", bus.cancel, 0);

        // Reset in the middle of an edit
        cyc(1, 0, 0, 0, 0);
        idle_cyc(1);
        cyc(0, 0, 0, 1, 0);
        rst_n = 0;
        idle_cyc(1);
        chk("midrst_state",  bus.state, 2'd0);
        chk("midrst_edit",   bus.edit_val, 48'h000000000101);
        chk("midrst_commit", bus.commit, 0);
        chk("midrst_cancel", bus.cancel, 0);
        rst_n = 1;

        // Randomized traffic, with quiet stretches long enough to time out
        ru = 0; rd = 0;
        for (int k = 0; k < 3000; k++) begin
            if (k % 300 == 0) begin
                for (int i = 0; i < NF; i++) begin
                    lo = lo_of(i); hi = hi_of(i);
                    if ($urandom_range(0, 9) < 7) lv[8*i +: 8] = i2bcd(int'($urandom_range(lo, hi)));
                    else                          lv[8*i +: 8] = 8'($urandom);
                end
                bus.live_val = lv;
            end
            rst_n = ($urandom_range(0, 999) != 0);
            if ((k % 400) >= 330) begin
                ru = 0; rd = 0; rp = 0; rr = 0; rl = 0;
            end else begin
                rp = ($urandom_range(0, 99) < 4);
                rr = ($urandom_range(0, 99) < 6);
                rl = ($urandom_range(0, 99) < 6);
                if ($urandom_range(0, 99) < 12) ru = !ru;
                if ($urandom_range(0, 99) < 10) rd = !rd;
            end
            cyc(rp, rr, rl, ru, rd);
        end
        rst_n = 1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
